// File: rtl/mem_access_unit.sv
// Memory stage: a 16-line direct-mapped, write-through, no-write-allocate data cache
// with a single-outstanding-request memory port and the MEM/WB pipeline register.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_readData2,
  input  logic [4:0]  in_writeReg,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_Branch,
  input  logic        in_RegWrite,
  input  logic        in_MemToReg,
  input  logic        in_zeroFlag,
  input  logic [31:0] in_branchTarget,
  output logic        hit,
  output logic        PCSrc,
  output logic [31:0] out_branchTarget,
  output logic [31:0] out_readData,
  output logic [31:0] out_ALUResult,
  output logic [4:0]  out_writeReg,
  output logic        out_RegWrite,
  output logic        out_MemToReg,
  output logic [15:0] miss_count,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_BUSY = 2'd2,
    WR_DONE = 2'd3
  } state_e;

  localparam int LINES = 16;

  state_e       state_q, state_d;

  logic [31:0]  data_q [LINES];
  logic [25:0]  tag_q  [LINES];
  logic [15:0]  valid_q;
  logic [15:0]  line_match;

  logic [3:0]   line_idx;
  logic [25:0]  line_tag;
  logic         line_hit;
  logic [31:0]  line_data;

  logic         is_read;
  logic         is_write;
  logic         ack;
  logic         fill_en;
  logic         update_en;
  logic         miss_inc;

  logic [31:0]  out_readData_d;
  logic         unused_addr_lsbs;

  assign line_idx  = in_ALUResult[5:2];
  assign line_tag  = in_ALUResult[31:6];
  assign line_data = data_q[line_idx];

  // Byte offset never reaches the cache or the memory port.
  assign unused_addr_lsbs = ^in_ALUResult[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_match
      assign line_match[gi] = valid_q[gi] && (tag_q[gi] == line_tag);
    end
  endgenerate

  assign line_hit = line_match[line_idx];

  // A store always wins over a load when both are flagged.
  assign is_write = in_MemWrite;
  assign is_read  = in_MemRead && !in_MemWrite;

  // Acks arriving without an outstanding request are discarded.
  assign ack = mem_ack && mem_req;

  assign PCSrc            = in_Branch & in_zeroFlag;
  assign out_branchTarget = in_branchTarget;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_write) begin
          state_d = WR_BUSY;
        end else if (is_read && !line_hit) begin
          state_d = RD_MISS;
        end
      end
      RD_MISS: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      WR_BUSY: begin
        if (ack) begin
          state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    hit       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    fill_en   = 1'b0;
    update_en = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_write) begin
          hit = 1'b0;
        end else if (is_read) begin
          hit      = line_hit;
          miss_inc = !line_hit;
        end else begin
          hit = 1'b1;
        end
      end
      RD_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {in_ALUResult[31:2], 2'b00};
        fill_en  = mem_ack;
      end
      WR_BUSY: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {in_ALUResult[31:2], 2'b00};
        mem_wdata = in_readData2;
        update_en = mem_ack && line_hit;
      end
      WR_DONE: begin
        hit = 1'b1;
      end
      default: begin
        hit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[line_idx] <= 1'b1;
    end
  end

  // Data and tag need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        data_q[line_idx] <= mem_rdata;
        tag_q[line_idx]  <= line_tag;
      end else if (update_en) begin
        data_q[line_idx] <= in_readData2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count <= 16'd0;
    end else if (miss_inc && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end

  // Only a load completing from IDLE carries cache data into MEM/WB.
  assign out_readData_d = ((state_q == IDLE) && is_read) ? line_data : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_readData  <= 32'd0;
      out_ALUResult <= 32'd0;
      out_writeReg  <= 5'd0;
      out_RegWrite  <= 1'b0;
      out_MemToReg  <= 1'b0;
    end else if (hit) begin
      out_readData  <= out_readData_d;
      out_ALUResult <= in_ALUResult;
      out_writeReg  <= in_writeReg;
      out_RegWrite  <= in_RegWrite;
      out_MemToReg  <= in_MemToReg;
    end
  end

endmodule
